// File: rtl/subleq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subleq_ctrl_pkg
// Description : Shared types and instruction-format helpers for the Subleq
//               fetch/execute controller.
// Revision    : 1.0 - initial release
// ============================================================================
package subleq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DEC    = 3'd1,
        ST_RDA    = 3'd2,
        ST_RDB    = 3'd3,
        ST_EXT_RD = 3'd4,
        ST_EXT_WR = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORM = 2'd0,
        MODE_IMM  = 2'd1,
        MODE_EXW  = 2'd2,
        MODE_EXR  = 2'd3
    } mode_t;

    // Flag positions above the three address fields
    localparam int C_OFS_EXR = 0;
    localparam int C_OFS_EXW = 1;
    localparam int C_OFS_IMM = 2;

    function automatic int inst_width(input int p_addr);
        return 3 + 3 * p_addr;
    endfunction

    function automatic int flag_bit(input int p_addr, input int ofs);
        return 3 * p_addr + ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/subleq_ctrl_indec.sv
`default_nettype none
// ============================================================================
// Module      : subleq_ctrl_indec
// Description : INDEC - splits an instruction word into flags and a/b/jt.
// Revision    : 1.0 - initial release
// ============================================================================
module subleq_ctrl_indec
    import subleq_ctrl_pkg::*;
#(
    parameter int P_ADDR = 8
) (
    input  logic [inst_width(P_ADDR)-1:0] inst,
    output logic                          imm,
    output logic                          exw,
    output logic                          exr,
    output logic [P_ADDR-1:0]             a,
    output logic [P_ADDR-1:0]             b,
    output logic [P_ADDR-1:0]             jt
);

    assign imm = inst[flag_bit(P_ADDR, C_OFS_IMM)];
    assign exw = inst[flag_bit(P_ADDR, C_OFS_EXW)];
    assign exr = inst[flag_bit(P_ADDR, C_OFS_EXR)];
    assign a   = inst[3*P_ADDR-1 -: P_ADDR];
    assign b   = inst[2*P_ADDR-1 -: P_ADDR];
    assign jt  = inst[P_ADDR-1:0];

endmodule
`default_nettype wire

// File: rtl/subleq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : subleq_ctrl
// Description : Subleq fetch/execute sequencer: PC, memory strobes, I/O port.
// Revision    : 1.0 - initial release
// ============================================================================
module subleq_ctrl
    import subleq_ctrl_pkg::*;
#(
    parameter int          P_ADDR   = 8,
    parameter int          P_DATA   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_en,
    output logic [P_ADDR-1:0]             imem_addr,
    input  logic [inst_width(P_ADDR)-1:0] imem_rdata,
    output logic                          dmem_en,
    output logic                          dmem_we,
    output logic [P_ADDR-1:0]             dmem_addr,
    output logic [P_DATA-1:0]             dmem_wdata,
    input  logic [P_DATA-1:0]             dmem_rdata,
    output logic                          ext_rd_req,
    input  logic                          ext_rd_ack,
    input  logic [P_DATA-1:0]             ext_rd_data,
    output logic                          ext_wr_valid,
    input  logic                          ext_wr_ready,
    output logic [P_DATA-1:0]             ext_wr_data,
    output logic [P_ADDR-1:0]             pc,
    output logic                          halted
);

    state_t            r_state, w_state_nxt;
    mode_t             r_mode, w_mode_dec;
    logic              r_live;
    logic [P_ADDR-1:0] r_pc, r_a, r_b, r_jt, w_pc_nxt;
    logic [P_DATA-1:0] r_opa, r_res, r_inval;
    logic              w_pc_upd, w_taken, w_halt_br;
    logic              w_imm, w_exw, w_exr;
    logic [P_ADDR-1:0] w_a, w_b, w_jt;

    subleq_ctrl_indec #(.P_ADDR(P_ADDR)) u_indec (
        .inst (imem_rdata),
        .imm  (w_imm),
        .exw  (w_exw),
        .exr  (w_exr),
        .a    (w_a),
        .b    (w_b),
        .jt   (w_jt)
    );

    assign w_mode_dec = w_exr ? MODE_EXR : w_exw ? MODE_EXW : w_imm ? MODE_IMM : MODE_NORM;

    // Port instructions branch on zero; memory instructions on signed <= 0
    assign w_taken   = (r_mode == MODE_EXR || r_mode == MODE_EXW) ? (r_res == '0)
                                                                  : (r_res[P_DATA-1] || r_res == '0);
    assign w_pc_nxt  = w_taken ? r_jt : r_pc + P_ADDR'(1);
    assign w_halt_br = w_taken && (r_jt == r_pc);

    assign imem_addr = r_pc;
    assign pc        = r_pc;

    // r_live holds off the first fetch so every strobe reads 0 straight out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_live  <= 1'b0;
            r_pc    <= P_ADDR'(RESET_PC);
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_pc_upd) r_pc <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_NORM;
            r_a     <= '0;
            r_b     <= '0;
            r_jt    <= '0;
            r_opa   <= '0;
            r_res   <= '0;
            r_inval <= '0;
        end else begin
            case (r_state)
                ST_DEC: begin
                    r_mode <= w_mode_dec;
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_jt   <= w_jt;
                end
                ST_RDA: begin
                    r_opa <= dmem_rdata;
                    r_res <= dmem_rdata - P_DATA'(r_b);
                end
                ST_RDB: r_res <= dmem_rdata - r_opa;
                ST_EXT_RD: begin
                    if (ext_rd_ack) begin
                        r_inval <= ext_rd_data;
                        r_res   <= ext_rd_data - P_DATA'(r_b);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_upd     = 1'b0;
        imem_en      = 1'b0;
        dmem_en      = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        ext_rd_req   = 1'b0;
        ext_wr_valid = 1'b0;
        ext_wr_data  = '0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (r_live) begin
                    imem_en     = 1'b1;
                    w_state_nxt = ST_DEC;
                end
            end
            ST_DEC: begin
                if (w_exr) begin
                    w_state_nxt = ST_EXT_RD;
                end else begin
                    dmem_en     = 1'b1;
                    dmem_addr   = w_a;
                    w_state_nxt = ST_RDA;
                end
            end
            ST_RDA: begin
                if (r_mode == MODE_EXW) begin
                    w_state_nxt = ST_EXT_WR;
                end else if (r_mode == MODE_IMM) begin
                    w_state_nxt = ST_WB;
                end else begin
                    dmem_en     = 1'b1;
                    dmem_addr   = r_b;
                    w_state_nxt = ST_RDB;
                end
            end
            ST_RDB: w_state_nxt = ST_WB;
            ST_EXT_RD: begin
                ext_rd_req = 1'b1;
                if (ext_rd_ack) w_state_nxt = ST_WB;
            end
            ST_EXT_WR: begin
                ext_wr_valid = 1'b1;
                ext_wr_data  = r_opa;
                if (ext_wr_ready) begin
                    w_pc_upd    = 1'b1;
                    w_state_nxt = w_halt_br ? ST_HALT : ST_FETCH;
                end
            end
            ST_WB: begin
                dmem_en     = 1'b1;
                dmem_we     = 1'b1;
                dmem_addr   = (r_mode == MODE_NORM) ? r_b : r_a;
                dmem_wdata  = (r_mode == MODE_EXR) ? r_inval : r_res;
                w_pc_upd    = 1'b1;
                w_state_nxt = w_halt_br ? ST_HALT : ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_subleq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_subleq_ctrl
// Description : Directed and random instruction bench with an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subleq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en, dmem_en, dmem_we, ext_rd_req, ext_wr_valid, halted;
    logic [3:0]  imem_addr, dmem_addr, pc;
    logic [14:0] imem_rdata = '0;
    logic [7:0]  dmem_wdata, dmem_rdata = '0, ext_wr_data;
    logic        ext_rd_ack = 1'b0, ext_wr_ready = 1'b0;
    logic [7:0]  ext_rd_data = '0;

    logic [14:0] imem     [16];
    logic [7:0]  dmem     [16];
    logic [7:0]  init_mem [16];
    logic [7:0]  ref_mem  [16];
    logic [3:0]  ref_pc;
    logic        ref_halt;

    int          rd_delay = 0, wr_delay = 0, rd_cnt = 0, wr_cnt = 0;
    logic [7:0]  rd_val = '0;
    int          checks = 0, errors = 0;

    subleq_ctrl #(.P_ADDR(4), .P_DATA(8), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .dmem_en      (dmem_en),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .ext_rd_req   (ext_rd_req),
        .ext_rd_ack   (ext_rd_ack),
        .ext_rd_data  (ext_rd_data),
        .ext_wr_valid (ext_wr_valid),
        .ext_wr_ready (ext_wr_ready),
        .ext_wr_data  (ext_wr_data),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) dmem[i] <= init_mem[i];
        end else if (dmem_en) begin
            if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
            else         dmem_rdata <= dmem[dmem_addr];
        end
    end

    // External device: answers after the configured number of wait cycles
    always @(negedge clk) begin
        if (ext_rd_req) begin rd_cnt = rd_cnt + 1; ext_rd_ack = (rd_cnt > rd_delay); end
        else begin rd_cnt = 0; ext_rd_ack = 1'b0; end
        if (ext_wr_valid) begin wr_cnt = wr_cnt + 1; ext_wr_ready = (wr_cnt > wr_delay); end
        else begin wr_cnt = 0; ext_wr_ready = 1'b0; end
        ext_rd_data = rd_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] enc(input logic imm, exw, exr, input logic [3:0] a, b, jt);
        return {imm, exw, exr, a, b, jt};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];
        ref_pc   = '0;
        ref_halt = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Execute one instruction on the DUT and compare against the ISA model
    task automatic run_inst(input int rdd, input int wrd, input logic [7:0] inv);
        logic [14:0] w;
        logic [3:0]  a, b, jt;
        logic [7:0]  res, out_exp;
        logic        taken;
        int n, lat, reads, writes, rcyc, wcyc, wr_bad, diffs;
        int exp_reads, exp_writes, exp_rcyc, exp_wcyc;
        rd_delay = rdd; wr_delay = wrd; rd_val = inv;
        n = 0;
        while (!imem_en && !halted && n < 20) begin @(negedge clk); #1; n++; end
        check("fetch_seen", imem_en, 1'b1);
        check("fetch_pc", pc, ref_pc);
        w = imem[ref_pc]; a = w[11:8]; b = w[7:4]; jt = w[3:0];
        out_exp = '0; exp_reads = 0; exp_writes = 1; exp_rcyc = 0; exp_wcyc = 0;
        if (w[12]) begin
            ref_mem[a] = inv; res = inv - {4'b0, b}; taken = (res == 0);
            lat = 4 + rdd; exp_rcyc = rdd + 1;
        end else if (w[13]) begin
            out_exp = ref_mem[a]; res = ref_mem[a] - {4'b0, b}; taken = (res == 0);
            lat = 4 + wrd; exp_reads = 1; exp_writes = 0; exp_wcyc = wrd + 1;
        end else if (w[14]) begin
            res = ref_mem[a] - {4'b0, b}; ref_mem[a] = res; taken = ($signed(res) <= 0);
            lat = 4; exp_reads = 1;
        end else begin
            res = ref_mem[b] - ref_mem[a]; ref_mem[b] = res; taken = ($signed(res) <= 0);
            lat = 5; exp_reads = 2;
        end
        ref_halt = taken && (jt == ref_pc);
        ref_pc   = taken ? jt : ref_pc + 4'd1;
        n = 0; reads = 0; writes = 0; rcyc = 0; wcyc = 0; wr_bad = 0;
        do begin
            @(negedge clk); #1; n++;
            if (imem_en || halted) break;
            if (dmem_en && !dmem_we) reads++;
            if (dmem_en && dmem_we) writes++;
            if (ext_rd_req) rcyc++;
            if (ext_wr_valid) begin wcyc++; if (ext_wr_data !== out_exp) wr_bad++; end
        end while (n < 40);
        diffs = 0;
        for (int i = 0; i < 16; i++) if (dmem[i] !== ref_mem[i]) diffs++;
        check("latency", n, lat);
        check("pc_next", pc, ref_pc);
        check("halted", halted, ref_halt);
        check("dmem_reads", reads, exp_reads);
        check("dmem_writes", writes, exp_writes);
        check("rd_req_cycles", rcyc, exp_rcyc);
        check("wr_valid_cycles", wcyc, exp_wcyc);
        check("wr_data_bad", wr_bad, 0);
        check("mem_diffs", diffs, 0);
    endtask

    initial begin
        int n;
        int en_seen;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin imem[i] = '0; init_mem[i] = '0; end
        init_mem[1] = 8'h10; init_mem[2] = 8'd5; init_mem[3] = 8'd3;
        init_mem[4] = 8'd3;  init_mem[5] = 8'd1; init_mem[6] = 8'd7;
        imem[0]  = enc(0, 0, 0, 4'd2, 4'd3, 4'd9);
        imem[9]  = enc(0, 0, 0, 4'd5, 4'd6, 4'd0);
        imem[10] = enc(1, 0, 0, 4'd4, 4'd3, 4'd6);
        imem[6]  = enc(0, 0, 1, 4'd7, 4'd5, 4'd12);
        imem[12] = enc(0, 0, 0, 4'd8, 4'd8, 4'd15);
        imem[15] = enc(0, 1, 0, 4'd1, 4'd1, 4'd3);
        repeat (3) @(negedge clk);
        #1;
        check("rst_imem_en", imem_en, 1'b0);
        check("rst_dmem_en", dmem_en, 1'b0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_ext_rd_req", ext_rd_req, 1'b0);
        check("rst_ext_wr_valid", ext_wr_valid, 1'b0);
        check("rst_pc", pc, 4'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_outs", {dmem_addr, dmem_wdata, ext_wr_data}, 20'd0);
        do_reset();

        run_inst(0, 0, 8'd0);          // normal taken: mem[3]=FE, pc=9
        check("dir_mem3", dmem[3], 8'hFE);
        run_inst(0, 0, 8'd0);          // normal not taken: mem[6]=6, pc=10
        check("dir_mem6", dmem[6], 8'd6);
        run_inst(0, 0, 8'd0);          // imm taken: mem[4]=0, pc=6
        check("dir_mem4", dmem[4], 8'd0);
        run_inst(3, 0, 8'd5);          // exr with 3-cycle ack delay
        check("dir_mem7", dmem[7], 8'd5);
        check("dir_pc12", pc, 4'd12);
        run_inst(0, 0, 8'd0);
        imem[0] = enc(0, 0, 0, 4'd0, 4'd0, 4'd0);
        run_inst(0, 0, 8'd0);          // exw at pc 15 wraps to 0
        check("dir_wrap_pc", pc, 4'd0);
        run_inst(0, 0, 8'd0);          // self-branch halts
        check("dir_halted", halted, 1'b1);
        en_seen = 0;
        repeat (10) begin @(negedge clk); #1; if (imem_en || !halted) en_seen++; end
        check("halt_quiet", en_seen, 0);

        // Reset while an external read is still pending
        imem[0] = enc(1, 0, 0, 4'd0, 4'd0, 4'd5);
        imem[5] = enc(0, 0, 1, 4'd3, 4'd0, 4'd1);
        init_mem[0] = 8'd0;
        do_reset();
        run_inst(0, 0, 8'd0);
        rd_delay = 1000;
        n = 0;
        while (!ext_rd_req && n < 20) begin @(negedge clk); #1; n++; end
        check("midrst_req_up", ext_rd_req, 1'b1);
        check("midrst_pc_before", pc, 4'd5);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_drop", ext_rd_req, 1'b0);
        check("midrst_pc", pc, 4'd0);
        check("midrst_strobes", {imem_en, dmem_en, ext_wr_valid}, 3'b000);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                imem[i]     = 15'($urandom);
                init_mem[i] = 8'($urandom);
            end
            do_reset();
            for (int s = 0; s < 12; s++) begin
                run_inst(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 8'($urandom));
                if (ref_halt) break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
